// File: rtl/mode_tick_gen.sv
// Two free-running tick dividers with a glitch-free mode selector that defers
// each switch to the target domain's next tick. Optional macro: SELECT_SYNC_EN.
module mode_tick_gen #(
    parameter int unsigned DIV_A = 500000,
    parameter int unsigned DIV_B = 50000000
) (
    input  logic clk,
    input  logic reset,
    input  logic select,
    output logic tick_a,
    output logic tick_b,
    output logic selected_tick,
    output logic mode,
    output logic switch_pending
);

    localparam int unsigned WA = (DIV_A > 2) ? $clog2(DIV_A) : 1;
    localparam int unsigned WB = (DIV_B > 2) ? $clog2(DIV_B) : 1;
    localparam logic [WA-1:0] A_MAX = WA'(DIV_A - 1);
    localparam logic [WB-1:0] B_MAX = WB'(DIV_B - 1);

    typedef enum logic [1:0] {
        RUN_A  = 2'b00,
        PEND_B = 2'b01,
        RUN_B  = 2'b10,
        PEND_A = 2'b11
    } state_t;

    logic [WA-1:0] cnt_a_q, cnt_a_d;
    logic [WB-1:0] cnt_b_q, cnt_b_d;
    logic          tick_a_q, tick_a_d;
    logic          tick_b_q, tick_b_d;
    logic          sel_q, sel_d;
    logic          sel_s;
    state_t        state_q, state_d;
    logic          mode_q, mode_d;
    logic          pend_q, pend_d;

`ifdef SELECT_SYNC_EN
    logic [1:0]    sync_q, sync_d;
`else
    logic          sync_q, sync_d;
`endif

    assign sel_s = sel_q;

    // Free-running dividers; ticks are registered copies of the terminal count.
    always_comb begin
        cnt_a_d  = cnt_a_q;
        cnt_b_d  = cnt_b_q;
        tick_a_d = 1'b0;
        tick_b_d = 1'b0;
        if (cnt_a_q == A_MAX) begin
            cnt_a_d  = '0;
            tick_a_d = 1'b1;
        end else begin
            cnt_a_d  = cnt_a_q + {{(WA-1){1'b0}}, 1'b1};
        end
        if (cnt_b_q == B_MAX) begin
            cnt_b_d  = '0;
            tick_b_d = 1'b1;
        end else begin
            cnt_b_d  = cnt_b_q + {{(WB-1){1'b0}}, 1'b1};
        end
    end

    // Input stage for the asynchronous select, ending in a sel register.
    always_comb begin
`ifdef SELECT_SYNC_EN
        sync_d = {sync_q[0], select};
        sel_d  = sync_q[1];
`else
        sync_d = select;
        sel_d  = sync_q;
`endif
    end

    // Mode FSM: a cancel beats a coincident target tick.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN_A: begin
                if (sel_s) state_d = PEND_B;
                else       state_d = RUN_A;
            end
            PEND_B: begin
                if (!sel_s)       state_d = RUN_A;
                else if (tick_b_d) state_d = RUN_B;
                else              state_d = PEND_B;
            end
            RUN_B: begin
                if (!sel_s) state_d = PEND_A;
                else        state_d = RUN_B;
            end
            PEND_A: begin
                if (sel_s)         state_d = RUN_B;
                else if (tick_a_d) state_d = RUN_A;
                else               state_d = PEND_A;
            end
            default: state_d = RUN_A;
        endcase
        mode_d = (state_d == RUN_B) || (state_d == PEND_A);
        pend_d = (state_d == PEND_A) || (state_d == PEND_B);
    end

    // State and output registers, cleared immediately on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_a_q  <= '0;
            cnt_b_q  <= '0;
            tick_a_q <= 1'b0;
            tick_b_q <= 1'b0;
            sync_q   <= '0;
            sel_q    <= 1'b0;
            state_q  <= RUN_A;
            mode_q   <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            cnt_a_q  <= cnt_a_d;
            cnt_b_q  <= cnt_b_d;
            tick_a_q <= tick_a_d;
            tick_b_q <= tick_b_d;
            sync_q   <= sync_d;
            sel_q    <= sel_d;
            state_q  <= state_d;
            mode_q   <= mode_d;
            pend_q   <= pend_d;
        end
    end

    assign tick_a         = tick_a_q;
    assign tick_b         = tick_b_q;
    assign mode           = mode_q;
    assign switch_pending = pend_q;
    assign selected_tick  = mode_q ? tick_b_q : tick_a_q;

endmodule

// File: tb/tb_mode_tick_gen.sv
// Table-driven bench for mode_tick_gen with DIV_A=10, DIV_B=100; the expected
// select latency follows SELECT_SYNC_EN.
module tb_mode_tick_gen;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic select = 1'b0;
    logic tick_a, tick_b, selected_tick, mode, switch_pending;

    mode_tick_gen #(.DIV_A(10), .DIV_B(100)) dut (
        .clk(clk), .reset(reset), .select(select),
        .tick_a(tick_a), .tick_b(tick_b), .selected_tick(selected_tick),
        .mode(mode), .switch_pending(switch_pending)
    );

    always #5 clk = ~clk;

`ifdef SELECT_SYNC_EN
    localparam int L = 3;
`else
    localparam int L = 2;
`endif

    // exp = {tick_a, tick_b, selected_tick, mode, switch_pending}
    typedef struct {
        int         run;
        int         cyc;
        logic       sel;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    function automatic void add(int run, int c, logic s, logic [4:0] e);
        vec_t v;
        v.run = run; v.cyc = c; v.sel = s; v.exp = e;
        vecs.push_back(v);
    endfunction

    task automatic goto(int n);
        while (cyc < n) begin
            @(posedge clk);
            cyc++;
        end
        #1;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        select = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        cyc   = 0;
    endtask

    task automatic chk(string nm, logic [4:0] exp);
        logic [4:0] act;
        act = {tick_a, tick_b, selected_tick, mode, switch_pending};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual(ta,tb,st,md,pd)=%b expected=%b", nm, act, exp);
        end
    endtask

    initial begin
        int cur_run;

        // run 1: power-up in A, switch A->B at 205, switch B->A at 605
        add(1, 9,       1'b0, 5'b00000);
        add(1, 10,      1'b0, 5'b10100);
        add(1, 11,      1'b0, 5'b00000);
        add(1, 100,     1'b0, 5'b11100);
        add(1, 200,     1'b0, 5'b11100);
        add(1, 204,     1'b1, 5'b00000);
        add(1, 204 + L, 1'b1, 5'b00000);
        add(1, 205 + L, 1'b1, 5'b00001);
        add(1, 210,     1'b1, 5'b10101);
        add(1, 290,     1'b1, 5'b10101);
        add(1, 299,     1'b1, 5'b00001);
        add(1, 300,     1'b1, 5'b11110);
        add(1, 310,     1'b1, 5'b10010);
        add(1, 400,     1'b1, 5'b11110);
        add(1, 600,     1'b1, 5'b11110);
        add(1, 604,     1'b0, 5'b00010);
        add(1, 604 + L, 1'b0, 5'b00010);
        add(1, 605 + L, 1'b0, 5'b00011);
        add(1, 609,     1'b0, 5'b00011);
        add(1, 610,     1'b0, 5'b10100);
        add(1, 700,     1'b0, 5'b11100);
        // run 2: cancelled request in A, then cancel coinciding with tick_b
        add(2, 10,      1'b0, 5'b10100);
        add(2, 504,     1'b1, 5'b00000);
        add(2, 504 + L, 1'b1, 5'b00000);
        add(2, 505 + L, 1'b1, 5'b00001);
        add(2, 510,     1'b1, 5'b10101);
        add(2, 519,     1'b0, 5'b00001);
        add(2, 520,     1'b0, 5'b10101);
        add(2, 519 + L, 1'b0, 5'b00001);
        add(2, 520 + L, 1'b0, 5'b00000);
        add(2, 530,     1'b0, 5'b10100);
        add(2, 804,     1'b1, 5'b00000);
        add(2, 805 + L, 1'b1, 5'b00001);
        add(2, 899 - L, 1'b0, 5'b00001);
        add(2, 899,     1'b0, 5'b00001);
        add(2, 900,     1'b0, 5'b11100);
        add(2, 910,     1'b0, 5'b10100);
        add(2, 1000,    1'b0, 5'b11100);

        #1;
        chk("reset_state", 5'b00000);

        cur_run = 0;
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].run != cur_run) begin
                do_reset();
                cur_run = vecs[i].run;
            end
            goto(vecs[i].cyc);
            chk($sformatf("run%0d_cyc%0d", vecs[i].run, vecs[i].cyc), vecs[i].exp);
            select = vecs[i].sel;
        end

        // run 3: asynchronous reset in the middle of PEND_B
        do_reset();
        goto(204);
        select = 1'b1;
        goto(249);
        chk("pend_before_reset", 5'b00001);
        goto(250);
        chk("tick_before_reset", 5'b10101);
        reset = 1'b1;
        #1;
        chk("async_reset_clear", 5'b00000);
        repeat (3) @(posedge clk);
        #1;
        chk("held_in_reset", 5'b00000);
        select = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        cyc   = 0;
        goto(9);
        chk("post_reset_cyc9", 5'b00000);
        goto(10);
        chk("post_reset_cyc10", 5'b10100);
        goto(100);
        chk("post_reset_cyc100", 5'b11100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
